// File: rtl/cdb_arbiter.sv
// Two-source (ALU, LSB) round-robin arbiter feeding one registered common data bus.
// Define CDB_ARBITER_BYPASS_EN to let a winning push into an empty FIFO go straight onto the CDB.
module cdb_arbiter #(
    parameter int ROB_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_pos,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_pos,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_pos,
    output logic [DATA_W-1:0] cdb_value,
    output logic              cdb_src
);
    localparam int            PW   = $clog2(FIFO_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    // Source index 0 = ALU, 1 = LSB throughout.
    logic [1:0]             in_vld;
    logic [1:0][ROB_W-1:0]  in_pos;
    logic [1:0][DATA_W-1:0] in_val;

    logic [ROB_W-1:0]   pos_mem_q [2][FIFO_DEPTH];
    logic [DATA_W-1:0]  val_mem_q [2][FIFO_DEPTH];
    logic [1:0][PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]   cdb_pos_q, cdb_pos_d;
    logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
    logic               cdb_src_q, cdb_src_d;

    logic [1:0] req, eff_req, byp, ready, push, wr, pop;
    logic       win, grant, take_byp;

    assign in_vld = {lsb_valid, alu_valid};
    assign in_pos = {lsb_pos, alu_pos};
    assign in_val = {lsb_value, alu_value};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            req[s]   = cnt_q[s] != '0;
            ready[s] = rdy & ~flush & (cnt_q[s] < FULL);
            push[s]  = in_vld[s] & ready[s] & (in_pos[s] != '0);
        end
`ifdef CDB_ARBITER_BYPASS_EN
        byp = push & ~req;
`else
        byp = '0;
`endif
        eff_req  = req | byp;
        win      = (&eff_req) ? prio_q : eff_req[1];
        grant    = rdy & ~flush & (|eff_req);
        take_byp = grant & byp[win];
        pop      = '0;
        wr       = push;
        if (grant && !take_byp) pop[win] = 1'b1;
        // A bypassed entry is consumed directly and never occupies its FIFO.
        if (take_byp) wr[win] = 1'b0;
    end

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        cdb_valid_d = cdb_valid_q;
        cdb_pos_d   = cdb_pos_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        if (rdy && flush) begin
            wp_d        = '0;
            rp_d        = '0;
            cnt_d       = '0;
            prio_d      = 1'b0;
            cdb_valid_d = 1'b0;
            cdb_pos_d   = '0;
        end else if (rdy) begin
            for (int s = 0; s < 2; s++) begin
                wp_d[s]  = wp_q[s] + PW'(wr[s]);
                rp_d[s]  = rp_q[s] + PW'(pop[s]);
                cnt_d[s] = cnt_q[s] + CW'(wr[s]) - CW'(pop[s]);
            end
            cdb_valid_d = grant;
            if (grant) begin
                cdb_pos_d   = take_byp ? in_pos[win] : pos_mem_q[win][rp_q[win]];
                cdb_value_d = take_byp ? in_val[win] : val_mem_q[win][rp_q[win]];
                cdb_src_d   = win;
                prio_d      = ~win;
            end else begin
                cdb_pos_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            cdb_valid_q <= 1'b0;
            cdb_pos_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_pos_q   <= cdb_pos_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr[s]) begin
                pos_mem_q[s][wp_q[s]] <= in_pos[s];
                val_mem_q[s][wp_q[s]] <= in_val[s];
            end
        end
    end

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];
    assign cdb_valid = cdb_valid_q;
    assign cdb_pos   = cdb_pos_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int D      = 2;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    logic alu_valid, lsb_valid, alu_ready, lsb_ready;
    logic [ROB_W-1:0]  alu_pos, lsb_pos, cdb_pos;
    logic [DATA_W-1:0] alu_value, lsb_value, cdb_value;
    logic cdb_valid, cdb_src;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [ROB_W-1:0]  pos;
        logic [DATA_W-1:0] val;
    } ent_t;

    ent_t qa[$];
    ent_t ql[$];
    logic              m_valid, m_src, m_prio;
    logic [ROB_W-1:0]  m_pos;
    logic [DATA_W-1:0] m_val;
    int                seen[$];

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_valid(alu_valid), .alu_pos(alu_pos), .alu_value(alu_value), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_pos(lsb_pos), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_pos(cdb_pos), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    // Advance one clock: predict the post-edge state from the current inputs, then
    // let the edge happen and log what the bus broadcast.
    task automatic cycle();
        bit   pa, pl, wa, wl;
        int   w;
        ent_t e, ia, il;
        ia.pos = alu_pos; ia.val = alu_value;
        il.pos = lsb_pos; il.val = lsb_value;
        e = '0;
        if (rst) begin
            qa.delete(); ql.delete();
            m_valid = 0; m_pos = '0; m_val = '0; m_src = 0; m_prio = 0;
        end else if (rdy && flush) begin
            qa.delete(); ql.delete();
            m_valid = 0; m_pos = '0; m_prio = 0;
        end else if (rdy) begin
            pa = alu_valid && qa.size() < D && alu_pos != 0;
            pl = lsb_valid && ql.size() < D && lsb_pos != 0;
            wa = qa.size() > 0;
            wl = ql.size() > 0;
`ifdef CDB_ARBITER_BYPASS_EN
            wa = wa || pa;
            wl = wl || pl;
`endif
            w = -1;
            if (wa && wl) w = m_prio ? 1 : 0;
            else if (wa)  w = 0;
            else if (wl)  w = 1;
            if (w == 0) begin
                if (qa.size() > 0) e = qa.pop_front();
                else begin e = ia; pa = 0; end
            end else if (w == 1) begin
                if (ql.size() > 0) e = ql.pop_front();
                else begin e = il; pl = 0; end
            end
            if (pa) qa.push_back(ia);
            if (pl) ql.push_back(il);
            if (w < 0) begin
                m_valid = 0; m_pos = '0;
            end else begin
                m_valid = 1; m_pos = e.pos; m_val = e.val;
                m_src = (w == 1); m_prio = (w != 1);
            end
        end
        @(posedge clk);
        #1;
        if (!rst && rdy && cdb_valid) seen.push_back(int'(cdb_pos));
    endtask

    task automatic drive_idle();
        alu_valid = 0; lsb_valid = 0; alu_pos = '0; lsb_pos = '0;
    endtask

    task automatic drive_flush();
        drive_idle();
        flush = 1; cycle(); flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; flush = 0;
        alu_valid = 1; alu_pos = 3; alu_value = 32'h55;
        lsb_valid = 1; lsb_pos = 6; lsb_value = 32'h66;
        cycle(); cycle();
        rst = 0; drive_idle(); #1;
        tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
        tests++; if (cdb_pos !== '0) begin fails++; $display("FAIL reset_pos: got %0d want 0", cdb_pos); end
        tests++; if (cdb_value !== '0) begin fails++; $display("FAIL reset_value: got %h want 0", cdb_value); end
        tests++; if (cdb_src !== 1'b0) begin fails++; $display("FAIL reset_src: got %b want 0", cdb_src); end
        tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
        tests++; if (lsb_ready !== 1'b1) begin fails++; $display("FAIL reset_lsb_ready: got %b want 1", lsb_ready); end
    endtask

    task automatic test_basic();
        int lat = 1;
`ifdef CDB_ARBITER_BYPASS_EN
        lat = 0;
`endif
        alu_valid = 1; alu_pos = 3; alu_value = 32'h11;
        cycle();
        drive_idle();
        for (int i = 0; i < lat; i++) begin
            tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL basic_early: got %b want 0", cdb_valid); end
            cycle();
        end
        tests++; if (cdb_valid !== 1'b1 || cdb_pos !== 4'd3) begin fails++; $display("FAIL basic_bcast: got v=%b pos=%0d want v=1 pos=3", cdb_valid, cdb_pos); end
        tests++; if (cdb_value !== 32'h11) begin fails++; $display("FAIL basic_value: got %h want 11", cdb_value); end
        tests++; if (cdb_src !== 1'b0) begin fails++; $display("FAIL basic_src: got %b want 0", cdb_src); end
        cycle();
        tests++; if (cdb_valid !== 1'b0 || cdb_pos !== '0) begin fails++; $display("FAIL basic_after: got v=%b pos=%0d want v=0 pos=0", cdb_valid, cdb_pos); end
    endtask

    task automatic test_round_robin();
        int exp_ord[4];
        exp_ord[0] = 1; exp_ord[1] = 5; exp_ord[2] = 2; exp_ord[3] = 6;
        drive_flush();
        seen.delete();
        for (int c = 0; c < 6; c++) begin
            alu_valid = (c < 2); alu_pos = (c < 2) ? ROB_W'(c + 1) : '0; alu_value = $urandom;
            lsb_valid = (c < 2); lsb_pos = (c < 2) ? ROB_W'(c + 5) : '0; lsb_value = $urandom;
            #1;
            tests++; if (alu_ready !== (qa.size() < D)) begin fails++; $display("FAIL rr_alu_ready: got %b want %b", alu_ready, qa.size() < D); end
            tests++; if (lsb_ready !== (ql.size() < D)) begin fails++; $display("FAIL rr_lsb_ready: got %b want %b", lsb_ready, ql.size() < D); end
            cycle();
        end
        drive_idle();
        tests++; if (seen.size() != 4) begin fails++; $display("FAIL rr_count: got %0d want 4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            tests++; if (seen[i] != exp_ord[i]) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, seen[i], exp_ord[i]); end
        end
    endtask

    task automatic test_fill();
        int ia = 0;
        bit ldone = 0;
        bit acc_a, acc_l;
        int n4 = 0, n7 = 0, n9 = 0;
        logic [ROB_W-1:0] ap [2];
        ap[0] = 4; ap[1] = 7;
        drive_flush();
        seen.delete();
        for (int c = 0; c < 10; c++) begin
            alu_valid = (ia < 2); alu_pos = (ia < 2) ? ap[ia] : '0; alu_value = $urandom;
            lsb_valid = !ldone; lsb_pos = 9; lsb_value = $urandom;
            #1;
            tests++; if (alu_ready !== (qa.size() < D)) begin fails++; $display("FAIL fill_alu_ready: got %b want %b (count %0d)", alu_ready, qa.size() < D, qa.size()); end
            acc_a = alu_valid && alu_ready;
            acc_l = lsb_valid && lsb_ready;
            cycle();
            if (acc_a) ia++;
            if (acc_l) ldone = 1;
        end
        drive_idle();
        foreach (seen[i]) begin
            if (seen[i] == 4) n4++;
            if (seen[i] == 7) n7++;
            if (seen[i] == 9) n9++;
        end
        tests++; if (n4 != 1 || n7 != 1 || n9 != 1 || seen.size() != 3)
            begin fails++; $display("FAIL fill_once: got n4=%0d n7=%0d n9=%0d total=%0d want 1 1 1 3", n4, n7, n9, seen.size()); end
    endtask

    task automatic test_flush();
        int bad = 0;
        int n2 = 0;
        alu_valid = 1; alu_pos = 6; alu_value = $urandom;
        lsb_valid = 1; lsb_pos = 8; lsb_value = $urandom;
        cycle();
        seen.delete();
        flush = 1; alu_valid = 1; alu_pos = 13; lsb_valid = 0;
        #1;
        tests++; if (alu_ready !== 1'b0 || lsb_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b%b want 00", alu_ready, lsb_ready); end
        cycle();
        flush = 0; drive_idle();
        tests++; if (cdb_valid !== 1'b0 || cdb_pos !== '0) begin fails++; $display("FAIL flush_bus: got v=%b pos=%0d want v=0 pos=0", cdb_valid, cdb_pos); end
        repeat (3) cycle();
        foreach (seen[i]) if (seen[i] == 6 || seen[i] == 8 || seen[i] == 13) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL flush_discard: got %0d stale broadcasts want 0", bad); end
        seen.delete();
        alu_valid = 1; alu_pos = 2; alu_value = $urandom;
        cycle();
        drive_idle();
        repeat (3) cycle();
        foreach (seen[i]) if (seen[i] == 2) n2++;
        tests++; if (n2 != 1 || seen.size() != 1) begin fails++; $display("FAIL flush_resume: got n2=%0d total=%0d want 1 1", n2, seen.size()); end
    endtask

    task automatic test_rdy_hold();
        bit found = 0;
        drive_flush();
        alu_valid = 1; alu_pos = 5; alu_value = $urandom;
        lsb_valid = 1; lsb_pos = 12; lsb_value = $urandom;
        cycle();
        drive_idle();
        for (int c = 0; c < 5 && !found; c++) begin
            if (cdb_valid === 1'b1 && cdb_pos === 4'd5) found = 1;
            else cycle();
        end
        tests++; if (!found) begin fails++; $display("FAIL hold_setup: pos 5 not broadcast within 5 cycles, got pos=%0d", cdb_pos); end
        seen.delete();
        rdy = 0; alu_valid = 1; alu_pos = 14; alu_value = $urandom;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (alu_ready !== 1'b0 || lsb_ready !== 1'b0) begin fails++; $display("FAIL hold_ready: got %b%b want 00", alu_ready, lsb_ready); end
            cycle();
            tests++; if (cdb_valid !== 1'b1 || cdb_pos !== 4'd5) begin fails++; $display("FAIL hold_bus: got v=%b pos=%0d want v=1 pos=5", cdb_valid, cdb_pos); end
        end
        rdy = 1; drive_idle();
        repeat (3) cycle();
        tests++; if (seen.size() != 1) begin fails++; $display("FAIL hold_resume_count: got %0d want 1", seen.size()); end
        else begin
            tests++; if (seen[0] != 12) begin fails++; $display("FAIL hold_resume: got %0d want 12", seen[0]); end
        end
        seen.delete();
        alu_valid = 1; alu_pos = 0; alu_value = $urandom;
        cycle();
        drive_idle();
        repeat (3) cycle();
        tests++; if (seen.size() != 0) begin fails++; $display("FAIL pos0_drop: got %0d broadcasts want 0", seen.size()); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            lsb_valid = ($urandom_range(0, 3) != 0);
            alu_pos   = ROB_W'($urandom_range(0, 15));
            lsb_pos   = ROB_W'($urandom_range(0, 15));
            alu_value = $urandom;
            lsb_value = $urandom;
            #1;
            tests++; if (alu_ready !== (rdy && !flush && qa.size() < D)) begin fails++; $display("FAIL rnd_alu_ready c=%0d: got %b want %b", c, alu_ready, rdy && !flush && qa.size() < D); end
            tests++; if (lsb_ready !== (rdy && !flush && ql.size() < D)) begin fails++; $display("FAIL rnd_lsb_ready c=%0d: got %b want %b", c, lsb_ready, rdy && !flush && ql.size() < D); end
            cycle();
            tests++; if (cdb_valid !== m_valid || cdb_pos !== m_pos) begin fails++; $display("FAIL rnd_bus c=%0d: got v=%b pos=%0d want v=%b pos=%0d", c, cdb_valid, cdb_pos, m_valid, m_pos); end
            if (m_valid) begin
                tests++; if (cdb_value !== m_val || cdb_src !== m_src) begin fails++; $display("FAIL rnd_data c=%0d: got val=%h src=%b want val=%h src=%b", c, cdb_value, cdb_src, m_val, m_src); end
            end
        end
        rdy = 1; flush = 0; drive_idle();
    endtask

    initial begin
        rst = 1; rdy = 1; flush = 0;
        alu_value = '0; lsb_value = '0;
        drive_idle();
        test_reset();
        test_basic();
        test_round_robin();
        test_fill();
        test_flush();
        test_rdy_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
